// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares the cpu_mem data port between cpu (M0) and loader (M1)
// Revision     : 1.0
// ============================================================================

package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    DT_BYTE = 2'd0,
    DT_HALF = 2'd1,
    DT_WORD = 2'd2
  } mem_dt_e;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [31:0]   m0_wd_i,
  input  mem_dt_e       m0_dt_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [31:0]   m0_rd_o,
  output logic          m0_stall_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [31:0]   m1_wd_i,
  input  mem_dt_e       m1_dt_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [31:0]   m1_rd_o,
  output logic [AW-1:0] m_addr_o,
  output logic          m_we_o,
  output logic [31:0]   m_wd_o,
  output mem_dt_e       m_dt_o,
  input  logic [31:0]   m_rd_i
);

  localparam int            HW         = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] c_MAX_HOLD = HW'(MAX_HOLD);
  localparam logic [HW-1:0] c_ONE      = HW'(1);

  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic [31:0]   rd_q, rd_d;
  logic          w_gnt0, w_gnt1, w_sel_we;

  // hold_q is nonzero only if last_q was also granted in the previous cycle.
  always_comb begin
    w_gnt0 = m0_req_i;
    w_gnt1 = m1_req_i;
    if (m0_req_i && m1_req_i) begin
      if ((hold_q != '0) && (hold_q < c_MAX_HOLD)) begin
        w_gnt0 = ~last_q;
        w_gnt1 = last_q;
      end else begin
        w_gnt0 = last_q;
        w_gnt1 = ~last_q;
      end
    end
  end

  always_comb begin
    m_addr_o = '0;
    m_wd_o   = '0;
    m_dt_o   = DT_BYTE;
    w_sel_we = 1'b0;
    if (w_gnt0) begin
      m_addr_o = m0_addr_i;
      m_wd_o   = m0_wd_i;
      m_dt_o   = m0_dt_i;
      w_sel_we = m0_we_i;
    end else if (w_gnt1) begin
      m_addr_o = m1_addr_i;
      m_wd_o   = m1_wd_i;
      m_dt_o   = m1_dt_i;
      w_sel_we = m1_we_i;
    end
  end

  always_comb begin
    last_d = last_q;
    hold_d = '0;
    if (w_gnt0 || w_gnt1) begin
      last_d = w_gnt1;
      if ((hold_q != '0) && (w_gnt1 == last_q)) begin
        hold_d = (hold_q == c_MAX_HOLD) ? hold_q : hold_q + c_ONE;
      end else begin
        hold_d = c_ONE;
      end
    end
    rv0_d = w_gnt0 & ~m0_we_i;
    rv1_d = w_gnt1 & ~m1_we_i;
    rd_d  = (rv0_d || rv1_d) ? m_rd_i : rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      hold_q <= '0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      last_q <= last_d;
      hold_q <= hold_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
      rd_q   <= rd_d;
    end
  end

  // A grant may be visible during reset, but memory must never be written then.
  assign m_we_o      = w_sel_we & ~rst;
  assign m0_gnt_o    = w_gnt0;
  assign m1_gnt_o    = w_gnt1;
  assign m0_stall_o  = m0_req_i & ~w_gnt0;
  assign m0_rvalid_o = rv0_q;
  assign m1_rvalid_o = rv1_q;
  assign m0_rd_o     = rd_q;
  assign m1_rd_o     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed and randomized checks of dmem_arbiter
// Revision        : 1.0
// ============================================================================

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int AW       = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_stall;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wd, m0_rd;
  mem_dt_e       m0_dt;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wd, m1_rd;
  mem_dt_e       m1_dt;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [31:0]   m_wd, m_rd;
  mem_dt_e       m_dt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_HOLD(MAX_HOLD), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wd_i(m0_wd),
    .m0_dt_i(m0_dt), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rd_o(m0_rd),
    .m0_stall_o(m0_stall),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wd_i(m1_wd),
    .m1_dt_i(m1_dt), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rd_o(m1_rd),
    .m_addr_o(m_addr), .m_we_o(m_we), .m_wd_o(m_wd), .m_dt_o(m_dt), .m_rd_i(m_rd)
  );

  // Small word memory standing in for cpu_mem (0x2000..0x200c -> words 0..3).
  logic [31:0] mem [0:15];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (m_we) begin
      mem[m_addr[5:2]] <= m_wd;
    end
  end
  assign m_rd = mem[m_addr[5:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0; m0_dt = DT_WORD;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0; m1_dt = DT_WORD;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_we} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs c%0d got %b exp 00000", c,
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_we});
      end
      n_vec++;
      if (m0_rd !== 32'h0) begin
        n_err++; $display("FAIL reset_rd got %h exp 0", m0_rd);
      end
    end
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h2000;
    m1_req = 1'b1; m1_addr = 32'h2004;
    #1;
    n_vec++;
    if ({m0_gnt, m1_gnt, m0_stall} !== 3'b100) begin
      n_err++; $display("FAIL reset_first_tie got %b exp 100", {m0_gnt, m1_gnt, m0_stall});
    end
    tick();
    idle();
  endtask

  task automatic test_single();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2000; m0_wd = 32'h20;
    #1;
    n_vec++;
    if ({m0_gnt, m_we, m0_stall} !== 3'b110) begin
      n_err++; $display("FAIL single_sw got %b exp 110", {m0_gnt, m_we, m0_stall});
    end
    n_vec++;
    if (m_addr !== 32'h2000 || m_wd !== 32'h20) begin
      n_err++; $display("FAIL single_sw_bus got %h/%h exp 2000/20", m_addr, m_wd);
    end
    tick();
    m0_we = 1'b0; m0_wd = '0;
    #1;
    n_vec++;
    if ({m0_gnt, m_we, m0_stall, m0_rvalid} !== 4'b1000) begin
      n_err++; $display("FAIL single_lw got %b exp 1000", {m0_gnt, m_we, m0_stall, m0_rvalid});
    end
    tick();
    idle();
    n_vec++;
    if (m0_rvalid !== 1'b1 || m0_rd !== 32'h20) begin
      n_err++; $display("FAIL single_ret got %b/%h exp 1/00000020", m0_rvalid, m0_rd);
    end
    tick();
    n_vec++;
    if (m0_rvalid !== 1'b0) begin
      n_err++; $display("FAIL single_ret_once got %b exp 0", m0_rvalid);
    end
  endtask

  task automatic test_contention();
    bit exp0;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h2000;
    m1_req = 1'b1; m1_addr = 32'h2004;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp0 = ((c / MAX_HOLD) % 2) == 0;
      n_vec++;
      if ({m0_gnt, m1_gnt, m0_stall} !== {exp0, ~exp0, ~exp0}) begin
        n_err++;
        $display("FAIL contention_gnt c%0d got %b exp %b", c,
                 {m0_gnt, m1_gnt, m0_stall}, {exp0, ~exp0, ~exp0});
      end
      tick();
      n_vec++;
      if ({m0_rvalid, m1_rvalid} !== {exp0, ~exp0} ||
          m0_rd !== (exp0 ? 32'h20 : 32'h0)) begin
        n_err++;
        $display("FAIL contention_ret c%0d got %b/%h exp %b", c,
                 {m0_rvalid, m1_rvalid}, m0_rd, {exp0, ~exp0});
      end
    end
    idle();
  endtask

  task automatic test_cross_order();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h2000;
    tick();
    idle();
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2004; m1_wd = 32'hdeadbeef;
    m0_req = 1'b1; m0_addr = 32'h2004;
    #1;
    n_vec++;
    if ({m0_gnt, m1_gnt, m_we, m0_stall} !== 4'b0111) begin
      n_err++; $display("FAIL cross_sw got %b exp 0111", {m0_gnt, m1_gnt, m_we, m0_stall});
    end
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    n_vec++;
    if ({m0_gnt, m1_gnt, m_we} !== 3'b100) begin
      n_err++; $display("FAIL cross_lw got %b exp 100", {m0_gnt, m1_gnt, m_we});
    end
    tick();
    idle();
    n_vec++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rd !== 32'hdeadbeef) begin
      n_err++; $display("FAIL cross_ret got %b/%h exp 10/deadbeef", {m0_rvalid, m1_rvalid}, m0_rd);
    end
  endtask

  task automatic test_withdraw();
    logic [31:0] snap;
    do_reset();
    snap = mem[3];
    m0_req = 1'b1; m0_addr = 32'h2000;
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200c; m1_wd = 32'h55aa55aa;
    #1;
    n_vec++;
    if ({m0_gnt, m1_gnt, m_we} !== 3'b100) begin
      n_err++; $display("FAIL withdraw_hold got %b exp 100", {m0_gnt, m1_gnt, m_we});
    end
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    n_vec++;
    if ({m1_gnt, m1_rvalid, m_we} !== 3'b000) begin
      n_err++; $display("FAIL withdraw_drop got %b exp 000", {m1_gnt, m1_rvalid, m_we});
    end
    tick();
    idle();
    tick();
    n_vec++;
    if (mem[3] !== snap || m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL withdraw_mem got %h/%b exp %h/0", mem[3], m1_rvalid, snap);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] snap;
    do_reset();
    snap = mem[2];
    m0_req = 1'b1; m0_addr = 32'h2008;
    #1;
    n_vec++;
    if (m0_gnt !== 1'b1) begin
      n_err++; $display("FAIL rstmid_gnt got %b exp 1", m0_gnt);
    end
    tick();
    idle();
    rst = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2008; m1_wd = 32'h12345678;
    #1;
    n_vec++;
    if (m_we !== 1'b0) begin
      n_err++; $display("FAIL rstmid_we got %b exp 0", m_we);
    end
    tick();
    idle();
    rst = 1'b0;
    n_vec++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_rvalid got %b exp 00", {m0_rvalid, m1_rvalid});
    end
    tick();
    n_vec++;
    if (mem[2] !== snap || m0_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_mem got %h/%b exp %h/0", mem[2], m0_rvalid, snap);
    end
  endtask

  // Expected grants come from the grant history: a master keeps the port under
  // contention only while its current run of consecutive grants is short.
  task automatic test_random();
    bit          pend[2];
    bit          rw[2];
    logic [31:0] ra[2];
    logic [31:0] rwd[2];
    mem_dt_e     rdt[2];
    logic [31:0] ref_mem[4];
    int          hist[$];
    int          last_any, eg, prev, run;
    bit          erv0, erv1, exp_we;
    logic [31:0] erd, exp_addr, got_rd;
    do_reset();
    for (int k = 0; k < 4; k++) ref_mem[k] = mem[k];
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; rw[m] = 1'b0; ra[m] = 32'h2000; rwd[m] = '0; rdt[m] = DT_WORD;
    end
    last_any = 1;
    erd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && $urandom_range(0, 19) == 0) begin
          pend[m] = 1'b0;
        end else if (!pend[m] && $urandom_range(0, 9) < 7) begin
          pend[m] = 1'b1;
          rw[m]   = 1'($urandom_range(0, 1));
          ra[m]   = 32'h2000 + 32'(4 * $urandom_range(0, 3));
          rwd[m]  = $urandom;
          rdt[m]  = mem_dt_e'($urandom_range(0, 2));
        end
      end
      m0_req = pend[0]; m0_we = rw[0]; m0_addr = ra[0]; m0_wd = rwd[0]; m0_dt = rdt[0];
      m1_req = pend[1]; m1_we = rw[1]; m1_addr = ra[1]; m1_wd = rwd[1]; m1_dt = rdt[1];
      #1;
      if (pend[0] && !pend[1]) eg = 0;
      else if (!pend[0] && pend[1]) eg = 1;
      else if (!pend[0] && !pend[1]) eg = -1;
      else begin
        prev = (hist.size() > 0) ? hist[$] : -1;
        if (prev < 0) eg = 1 - last_any;
        else begin
          run = 0;
          for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != prev) break;
            run++;
          end
          eg = (run < MAX_HOLD) ? prev : 1 - prev;
        end
      end
      exp_we   = (eg >= 0) ? rw[eg] : 1'b0;
      exp_addr = (eg >= 0) ? ra[eg] : 32'h0;
      n_vec++;
      if ({m0_gnt, m1_gnt, m0_stall} !== {eg == 0, eg == 1, pend[0] && eg != 0}) begin
        n_err++;
        $display("FAIL rand_gnt c%0d got %b exp %b", c, {m0_gnt, m1_gnt, m0_stall},
                 {eg == 0, eg == 1, pend[0] && eg != 0});
      end
      n_vec++;
      if (m_we !== exp_we || m_addr !== exp_addr) begin
        n_err++;
        $display("FAIL rand_bus c%0d got we %b addr %h exp we %b addr %h", c, m_we, m_addr,
                 exp_we, exp_addr);
      end
      if (eg >= 0) begin
        n_vec++;
        if (m_dt !== rdt[eg] || (exp_we && m_wd !== rwd[eg])) begin
          n_err++;
          $display("FAIL rand_mux c%0d got dt %0d wd %h exp dt %0d wd %h", c, m_dt, m_wd,
                   rdt[eg], rwd[eg]);
        end
      end
      hist.push_back(eg);
      erv0 = 1'b0;
      erv1 = 1'b0;
      if (eg >= 0) begin
        last_any = eg;
        if (rw[eg]) ref_mem[ra[eg][3:2]] = rwd[eg];
        else begin
          erd  = ref_mem[ra[eg][3:2]];
          erv0 = (eg == 0);
          erv1 = (eg == 1);
        end
        pend[eg] = 1'b0;
      end
      tick();
      got_rd = erv1 ? m1_rd : m0_rd;
      n_vec++;
      if ({m0_rvalid, m1_rvalid} !== {erv0, erv1} || ((erv0 || erv1) && got_rd !== erd)) begin
        n_err++;
        $display("FAIL rand_ret c%0d got %b/%h exp %b/%h", c, {m0_rvalid, m1_rvalid}, got_rd,
                 {erv0, erv1}, erd);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst     = 1'b1;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_cross_order();
    test_withdraw();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
